// File: rtl/hex_led_pkg.sv
// Shared definitions for the hex LED display blocks.
//   MAX_DIGITS : widest display any of these blocks supports
//   LED_OFF    : inactive level of the active-low anode/segment/dp lines
//   cnt_width  : bit width needed to count 0..div-1
package hex_led_pkg;

    localparam int MAX_DIGITS = 8;
    localparam logic LED_OFF = 1'b1;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/hex_led_lz_mask.sv
// Leading-zero suppression mask (combinational).
//   disp_data   : packed displayed value, digit i at [4i+3:4i]
//   lz_suppress : enable suppression
//   suppress    : bit i high when digit i must stay dark
// Digit i is dark when it and every more significant digit are zero.
// Digit 0 always shows so a zero value still displays "0".
module hex_led_lz_mask #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] disp_data,
    input  logic                lz_suppress,
    output logic [DIGITS-1:0]   suppress
);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_mask
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = lz_suppress &&
                    (disp_data[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

endmodule

// File: rtl/hex_led_scanner.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
//   clk, reset   : clock, synchronous active-high reset
//   data_in      : packed hex value, digit 0 least significant / rightmost
//   dp_in        : per-digit decimal point request, active-high
//   load         : one-cycle strobe capturing data_in / dp_in
//   lz_suppress  : blank leading zero digits when high
//   nibble       : current digit value for the downstream encoder
//   an_n         : digit enables, active-low, at most one low
//   dp_n         : decimal point, active-low
//   frame_done   : one-cycle pulse at each frame start
// New values are double-buffered and only reach the display at a frame
// boundary, so a frame never mixes old and new digits.
module hex_led_scanner
    import hex_led_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                lz_suppress,
    output logic [3:0]          nibble,
    output logic [DIGITS-1:0]   an_n,
    output logic                dp_n,
    output logic                frame_done
);

    localparam int CW = cnt_width(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [4*DIGITS-1:0]   disp_data_reg, pend_data_reg;
    logic [DIGITS-1:0]     disp_dp_reg, pend_dp_reg;
    logic                  pend_valid_reg;
    logic [3:0]            nibble_reg;
    logic [DIGITS-1:0]     an_n_reg;
    logic                  dp_n_reg;
    logic                  frame_done_reg;

    logic                  slot_end, frame_wrap, show, lit;
    logic [3:0]            digit_val [DIGITS];
    logic [DIGITS-1:0]     suppress;
    logic [3:0]            nibble_next;
    logic [DIGITS-1:0]     an_n_next;
    logic                  dp_n_next;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = disp_data_reg[4*gi +: 4];
        end
    endgenerate

    hex_led_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
        .disp_data   (disp_data_reg),
        .lz_suppress (lz_suppress),
        .suppress    (suppress)
    );

    assign slot_end   = (cnt_reg == CNT_LAST);
    assign frame_wrap = slot_end && (idx_reg == IDX_LAST);
    // Phase comes straight from the slot counter: BLANK first, then SHOW.
    assign show       = (cnt_reg >= BLANK_END);
    assign lit        = show && !suppress[idx_reg];

    always_comb begin
        // Nibble follows the slot in both phases so the encoder settles
        // while the anodes are still off.
        nibble_next = digit_val[idx_reg];
        an_n_next   = {DIGITS{LED_OFF}};
        dp_n_next   = LED_OFF;
        if (lit) begin
            an_n_next[idx_reg] = ~LED_OFF;
            if (disp_dp_reg[idx_reg]) begin
                dp_n_next = ~LED_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            disp_data_reg  <= '0;
            disp_dp_reg    <= '0;
            pend_data_reg  <= '0;
            pend_dp_reg    <= '0;
            pend_valid_reg <= 1'b0;
            nibble_reg     <= '0;
            an_n_reg       <= {DIGITS{LED_OFF}};
            dp_n_reg       <= LED_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= frame_wrap ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (load && frame_wrap) begin
                // Load coinciding with the boundary bypasses the buffer.
                disp_data_reg  <= data_in;
                disp_dp_reg    <= dp_in;
                pend_data_reg  <= data_in;
                pend_dp_reg    <= dp_in;
                pend_valid_reg <= 1'b0;
            end else if (load) begin
                pend_data_reg  <= data_in;
                pend_dp_reg    <= dp_in;
                pend_valid_reg <= 1'b1;
            end else if (frame_wrap && pend_valid_reg) begin
                disp_data_reg  <= pend_data_reg;
                disp_dp_reg    <= pend_dp_reg;
                pend_valid_reg <= 1'b0;
            end

            nibble_reg     <= nibble_next;
            an_n_reg       <= an_n_next;
            dp_n_reg       <= dp_n_next;
            frame_done_reg <= frame_wrap;
        end
    end

    assign nibble     = nibble_reg;
    assign an_n       = an_n_reg;
    assign dp_n       = dp_n_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hex_led_scanner.sv
// Directed bench for hex_led_scanner with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// Cycle c (relative to reset release) has slot index (c/8)%4, position c%8;
// outputs show the decode of the previous cycle.
module tb_hex_led_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int an_cnt [4];
    int dp_low_cnt = 0;
    int dp_stray_cnt = 0;

    hex_led_scanner #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .load        (load),
        .lz_suppress (lz_suppress),
        .nibble      (nibble),
        .an_n        (an_n),
        .dp_n        (dp_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s cyc=%0d val=%h", tag, cyc, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) an_cnt[i] = 0;
        dp_low_cnt = 0;
        dp_stray_cnt = 0;
    endtask

    task automatic accumulate();
        for (int i = 0; i < 4; i++) if (!an_n[i]) an_cnt[i]++;
        if (!dp_n) begin
            dp_low_cnt++;
            if (an_n != 4'b1011) dp_stray_cnt++;
        end
    endtask

    initial begin
        logic [3:0] an_exp;
        int r;
        clear_counts();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        for (int cyc = 0; cyc < 450; cyc++) begin
            // ---------------- checks for the current cycle ----------------
            if (cyc <= 16) begin
                if (cyc <= 2 || cyc == 9 || cyc == 10) an_exp = 4'b1111;
                else if (cyc <= 8)                   an_exp = 4'b1110;
                else                                 an_exp = 4'b1101;
                check("reset_an", cyc, 32'(an_n), 32'(an_exp));
                check("reset_dp", cyc, 32'(dp_n), 32'd1);
            end
            if (cyc == 0) begin
                check("reset_nib", cyc, 32'(nibble), 32'd0);
                check("reset_fd", cyc, 32'(frame_done), 32'd0);
            end
            case (cyc)
                13, 29: check("tear_old", cyc, 32'(nibble), 32'h0);
                31:     check("fd_low", cyc, 32'(frame_done), 32'd0);
                32:     check("fd_high", cyc, 32'(frame_done), 32'd1);
                33:     check("fd_pulse", cyc, 32'(frame_done), 32'd0);
                37:     check("walk_d0", cyc, 32'(nibble), 32'h4);
                45:     check("walk_d1", cyc, 32'(nibble), 32'h3);
                53:     check("walk_d2", cyc, 32'(nibble), 32'h2);
                61:     check("walk_d3", cyc, 32'(nibble), 32'h1);
                64:     check("fd_f2", cyc, 32'(frame_done), 32'd1);
                69:     check("wrap_d0", cyc, 32'(nibble), 32'hD);
                77:     check("wrap_d1", cyc, 32'(nibble), 32'hC);
                85:     check("wrap_d2", cyc, 32'(nibble), 32'hB);
                93:     check("wrap_d3", cyc, 32'(nibble), 32'hA);
                101:    check("next_d0", cyc, 32'(nibble), 32'h5);
                125:    check("next_d3", cyc, 32'(nibble), 32'h5);
                405: begin
                    check("pre_rst_an", cyc, 32'(an_n), 32'(4'b1011));
                    check("pre_rst_dp", cyc, 32'(dp_n), 32'd0);
                end
                406: begin
                    check("mid_rst_an", cyc, 32'(an_n), 32'(4'b1111));
                    check("mid_rst_dp", cyc, 32'(dp_n), 32'd1);
                    check("mid_rst_nib", cyc, 32'(nibble), 32'd0);
                    check("mid_rst_fd", cyc, 32'(frame_done), 32'd0);
                end
                default: ;
            endcase

            if ((cyc >= 161 && cyc <= 192) || (cyc >= 225 && cyc <= 256) ||
                (cyc >= 289 && cyc <= 320) || (cyc >= 353 && cyc <= 384))
                accumulate();
            if (cyc == 193) begin
                check("lz70_d0", cyc, 32'(an_cnt[0]), 32'd6);
                check("lz70_d1", cyc, 32'(an_cnt[1]), 32'd6);
                check("lz70_d2", cyc, 32'(an_cnt[2]), 32'd0);
                check("lz70_d3", cyc, 32'(an_cnt[3]), 32'd0);
                clear_counts();
            end
            if (cyc == 257) begin
                check("lz00_d0", cyc, 32'(an_cnt[0]), 32'd6);
                check("lz00_d1", cyc, 32'(an_cnt[1]), 32'd0);
                check("lz00_d2", cyc, 32'(an_cnt[2]), 32'd0);
                check("lz00_d3", cyc, 32'(an_cnt[3]), 32'd0);
                clear_counts();
            end
            if (cyc == 321) begin
                check("dp_low", cyc, 32'(dp_low_cnt), 32'd6);
                check("dp_stray", cyc, 32'(dp_stray_cnt), 32'd0);
                check("dp_lz_d3", cyc, 32'(an_cnt[3]), 32'd0);
                check("dp_d2_on", cyc, 32'(an_cnt[2]), 32'd6);
                clear_counts();
            end
            if (cyc == 385) begin
                check("dp_supp", cyc, 32'(dp_low_cnt), 32'd0);
                clear_counts();
            end

            // Post mid-frame reset: release at 407 is the new cycle 0.
            if (cyc >= 407) begin
                r = cyc - 407;
                case (r)
                    0:  check("rr_an0", cyc, 32'(an_n), 32'(4'b1111));
                    3:  check("rr_an3", cyc, 32'(an_n), 32'(4'b1110));
                    5:  check("rr_nib", cyc, 32'(nibble), 32'd0);
                    21: begin
                        check("rr_an_d2", cyc, 32'(an_n), 32'(4'b1011));
                        check("rr_dp_clr", cyc, 32'(dp_n), 32'd1);
                    end
                    31: check("rr_fd_low", cyc, 32'(frame_done), 32'd0);
                    32: check("rr_fd_high", cyc, 32'(frame_done), 32'd1);
                    37: check("rr_pend_gone", cyc, 32'(nibble), 32'd0);
                    default: ;
                endcase
            end

            // ---------------- stimulus for the current cycle ----------------
            load = 1'b0;
            case (cyc)
                5:   begin load = 1'b1; data_in = 16'h1234; dp_in = 4'b0000; end
                63:  begin load = 1'b1; data_in = 16'hABCD; end
                64:  begin load = 1'b1; data_in = 16'h5555; end
                130: begin load = 1'b1; data_in = 16'h0070; lz_suppress = 1'b1; end
                200: begin load = 1'b1; data_in = 16'h0000; end
                260: begin load = 1'b1; data_in = 16'h0100; dp_in = 4'b0100; end
                330: begin load = 1'b1; data_in = 16'h0000; dp_in = 4'b0100; end
                386: lz_suppress = 1'b0;
                390: begin load = 1'b1; data_in = 16'h9999; dp_in = 4'b1111; end
                405: reset = 1'b1;
                407: reset = 1'b0;
                default: ;
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
